// File: rtl/issue_stage_pkg.sv
// rtl/issue_stage_pkg.sv - shared op enumeration, RV32I opcode/funct constants and field ranges
`ifndef ISSUE_STAGE_PKG_MACROS
`define ISSUE_STAGE_PKG_MACROS
`define INST_OPCODE 6:0
`define INST_RD     11:7
`define INST_FUNCT3 14:12
`define INST_RS1    19:15
`define INST_RS2    24:20
`endif

package issue_stage_pkg;
    localparam int NO_DEP = 0;

    localparam logic [5:0] OPENUM_NOP   = 6'd0;
    localparam logic [5:0] OPENUM_LUI   = 6'd1;
    localparam logic [5:0] OPENUM_AUIPC = 6'd2;
    localparam logic [5:0] OPENUM_JAL   = 6'd3;
    localparam logic [5:0] OPENUM_JALR  = 6'd4;
    localparam logic [5:0] OPENUM_BEQ   = 6'd5;
    localparam logic [5:0] OPENUM_BNE   = 6'd6;
    localparam logic [5:0] OPENUM_BLT   = 6'd7;
    localparam logic [5:0] OPENUM_BGE   = 6'd8;
    localparam logic [5:0] OPENUM_BLTU  = 6'd9;
    localparam logic [5:0] OPENUM_BGEU  = 6'd10;
    localparam logic [5:0] OPENUM_LB    = 6'd11;
    localparam logic [5:0] OPENUM_LH    = 6'd12;
    localparam logic [5:0] OPENUM_LW    = 6'd13;
    localparam logic [5:0] OPENUM_LBU   = 6'd14;
    localparam logic [5:0] OPENUM_LHU   = 6'd15;
    localparam logic [5:0] OPENUM_SB    = 6'd16;
    localparam logic [5:0] OPENUM_SH    = 6'd17;
    localparam logic [5:0] OPENUM_SW    = 6'd18;
    localparam logic [5:0] OPENUM_ADDI  = 6'd19;
    localparam logic [5:0] OPENUM_SLTI  = 6'd20;
    localparam logic [5:0] OPENUM_SLTIU = 6'd21;
    localparam logic [5:0] OPENUM_XORI  = 6'd22;
    localparam logic [5:0] OPENUM_ORI   = 6'd23;
    localparam logic [5:0] OPENUM_ANDI  = 6'd24;
    localparam logic [5:0] OPENUM_SLLI  = 6'd25;
    localparam logic [5:0] OPENUM_SRLI  = 6'd26;
    localparam logic [5:0] OPENUM_SRAI  = 6'd27;
    localparam logic [5:0] OPENUM_ADD   = 6'd28;
    localparam logic [5:0] OPENUM_SUB   = 6'd29;
    localparam logic [5:0] OPENUM_SLL   = 6'd30;
    localparam logic [5:0] OPENUM_SLT   = 6'd31;
    localparam logic [5:0] OPENUM_SLTU  = 6'd32;
    localparam logic [5:0] OPENUM_XOR   = 6'd33;
    localparam logic [5:0] OPENUM_SRL   = 6'd34;
    localparam logic [5:0] OPENUM_SRA   = 6'd35;
    localparam logic [5:0] OPENUM_OR    = 6'd36;
    localparam logic [5:0] OPENUM_AND   = 6'd37;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;
    localparam logic [2:0] FUNCT3_B    = 3'b000;
    localparam logic [2:0] FUNCT3_H    = 3'b001;
    localparam logic [2:0] FUNCT3_W    = 3'b010;
    localparam logic [2:0] FUNCT3_BU   = 3'b100;
    localparam logic [2:0] FUNCT3_HU   = 3'b101;
    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
endpackage

// File: rtl/issue_stage_operand_resolve.sv
// rtl/issue_stage_operand_resolve.sv - priority resolve of one operand from reg file, ROB and CDB channels
module operand_resolve
    import issue_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ROB_IDX_W = 4,
    parameter int NUM_CDB   = 2
) (
    input  logic [ROB_IDX_W-1:0]         dep_i,
    input  logic [XLEN-1:0]              reg_val_i,
    input  logic                         rob_ready_i,
    input  logic [XLEN-1:0]              rob_val_i,
    input  logic [NUM_CDB-1:0]           cdb_valid_i,
    input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_tag_i,
    input  logic [NUM_CDB*XLEN-1:0]      cdb_val_i,
    output logic [XLEN-1:0]              val_o,
    output logic [ROB_IDX_W-1:0]         dep_o
);
    logic hit;

    always_comb begin
        val_o = '0;
        dep_o = dep_i;
        hit   = 1'b0;
        if (dep_i == ROB_IDX_W'(NO_DEP)) begin
            val_o = reg_val_i;
        end else if (rob_ready_i) begin
            val_o = rob_val_i;
            dep_o = '0;
        end else begin
            // first matching channel claims the result
            for (int i = 0; i < NUM_CDB; i++) begin
                if (!hit && cdb_valid_i[i] && cdb_tag_i[i*ROB_IDX_W +: ROB_IDX_W] == dep_i) begin
                    hit   = 1'b1;
                    val_o = cdb_val_i[i*XLEN +: XLEN];
                    dep_o = '0;
                end
            end
        end
    end
endmodule

// File: rtl/issue_stage.sv
// rtl/issue_stage.sv - one-entry RV32I decode/issue holding stage with CDB wake-up and flush
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ROB_IDX_W = 4,
    parameter int NUM_CDB   = 2,
    parameter int OPENUM_W  = 6
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_in,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [XLEN-1:0]              if_pc,
    input  logic [31:0]                  if_inst,
    input  logic                         if_pred_br,
    output logic [4:0]                   reg_rs1_pos,
    output logic [4:0]                   reg_rs2_pos,
    input  logic [XLEN-1:0]              reg_rs1_val,
    input  logic [XLEN-1:0]              reg_rs2_val,
    input  logic [ROB_IDX_W-1:0]         reg_rs1_dep,
    input  logic [ROB_IDX_W-1:0]         reg_rs2_dep,
    output logic [ROB_IDX_W-1:0]         rob_rs1_check,
    output logic [ROB_IDX_W-1:0]         rob_rs2_check,
    input  logic                         rob_rs1_ready,
    input  logic                         rob_rs2_ready,
    input  logic [XLEN-1:0]              rob_rs1_val,
    input  logic [XLEN-1:0]              rob_rs2_val,
    input  logic [ROB_IDX_W-1:0]         rob_alloc_tag,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]      cdb_val,
    input  logic                         rob_full,
    input  logic                         rs_full,
    input  logic                         lsb_full,
    output logic                         issue_fire,
    output logic                         issue_to_rs,
    output logic                         issue_to_lsb,
    output logic [OPENUM_W-1:0]          issue_op,
    output logic [XLEN-1:0]              issue_rs1_val,
    output logic [XLEN-1:0]              issue_rs2_val,
    output logic [ROB_IDX_W-1:0]         issue_rs1_dep,
    output logic [ROB_IDX_W-1:0]         issue_rs2_dep,
    output logic [4:0]                   issue_rd,
    output logic [XLEN-1:0]              issue_imm,
    output logic [XLEN-1:0]              issue_pc,
    output logic                         issue_pred_br,
    output logic [ROB_IDX_W-1:0]         issue_rob_tag
);
    logic                 hold_valid_q, hold_valid_d;
    logic                 to_lsb_q, to_lsb_d;
    logic [OPENUM_W-1:0]  op_q, op_d;
    logic [XLEN-1:0]      rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
    logic [ROB_IDX_W-1:0] rs1_dep_q, rs1_dep_d, rs2_dep_q, rs2_dep_d;
    logic [4:0]           rd_q, rd_d;
    logic [XLEN-1:0]      imm_q, imm_d, pc_q, pc_d;
    logic                 pred_q, pred_d;

    logic [OPENUM_W-1:0]  dec_op;
    logic [4:0]           dec_rd;
    logic [31:0]          dec_imm32;
    logic                 dec_to_lsb, dec_use_rs1, dec_use_rs2, dec_known;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 alt;
    logic [31:0]          imm_i;

    logic [XLEN-1:0]      cap_rs1_val, cap_rs2_val, byp_rs1_val, byp_rs2_val;
    logic [ROB_IDX_W-1:0] cap_rs1_dep, cap_rs2_dep, byp_rs1_dep, byp_rs2_dep;
    logic                 capture;

    assign opcode = if_inst[`INST_OPCODE];
    assign funct3 = if_inst[`INST_FUNCT3];
    assign alt    = if_inst[30];
    assign imm_i  = {{20{if_inst[31]}}, if_inst[31:20]};

    always_comb begin
        dec_op      = OPENUM_W'(OPENUM_NOP);
        dec_rd      = if_inst[`INST_RD];
        dec_imm32   = imm_i;
        dec_to_lsb  = 1'b0;
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b0;
        dec_known   = 1'b1;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_op      = (opcode == OPC_LUI) ? OPENUM_W'(OPENUM_LUI) : OPENUM_W'(OPENUM_AUIPC);
                dec_imm32   = {if_inst[31:12], 12'b0};
                dec_use_rs1 = 1'b0;
            end
            OPC_JAL: begin
                dec_op      = OPENUM_W'(OPENUM_JAL);
                dec_imm32   = {{12{if_inst[31]}}, if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
                dec_use_rs1 = 1'b0;
            end
            OPC_JALR: begin
                dec_op    = OPENUM_W'(OPENUM_JALR);
                dec_known = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec_rd      = '0;
                dec_use_rs2 = 1'b1;
                dec_imm32   = {{20{if_inst[31]}}, if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
                case (funct3)
                    FUNCT3_BEQ:  dec_op = OPENUM_W'(OPENUM_BEQ);
                    FUNCT3_BNE:  dec_op = OPENUM_W'(OPENUM_BNE);
                    FUNCT3_BLT:  dec_op = OPENUM_W'(OPENUM_BLT);
                    FUNCT3_BGE:  dec_op = OPENUM_W'(OPENUM_BGE);
                    FUNCT3_BLTU: dec_op = OPENUM_W'(OPENUM_BLTU);
                    FUNCT3_BGEU: dec_op = OPENUM_W'(OPENUM_BGEU);
                    default:     dec_known = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec_to_lsb = 1'b1;
                case (funct3)
                    FUNCT3_B:  dec_op = OPENUM_W'(OPENUM_LB);
                    FUNCT3_H:  dec_op = OPENUM_W'(OPENUM_LH);
                    FUNCT3_W:  dec_op = OPENUM_W'(OPENUM_LW);
                    FUNCT3_BU: dec_op = OPENUM_W'(OPENUM_LBU);
                    FUNCT3_HU: dec_op = OPENUM_W'(OPENUM_LHU);
                    default:   dec_known = 1'b0;
                endcase
            end
            OPC_STORE: begin
                dec_to_lsb  = 1'b1;
                dec_rd      = '0;
                dec_use_rs2 = 1'b1;
                dec_imm32   = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
                case (funct3)
                    FUNCT3_B: dec_op = OPENUM_W'(OPENUM_SB);
                    FUNCT3_H: dec_op = OPENUM_W'(OPENUM_SH);
                    FUNCT3_W: dec_op = OPENUM_W'(OPENUM_SW);
                    default:  dec_known = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                case (funct3)
                    FUNCT3_ADD:  dec_op = OPENUM_W'(OPENUM_ADDI);
                    FUNCT3_SLT:  dec_op = OPENUM_W'(OPENUM_SLTI);
                    FUNCT3_SLTU: dec_op = OPENUM_W'(OPENUM_SLTIU);
                    FUNCT3_XOR:  dec_op = OPENUM_W'(OPENUM_XORI);
                    FUNCT3_OR:   dec_op = OPENUM_W'(OPENUM_ORI);
                    FUNCT3_AND:  dec_op = OPENUM_W'(OPENUM_ANDI);
                    FUNCT3_SLL: begin
                        dec_op    = OPENUM_W'(OPENUM_SLLI);
                        dec_imm32 = {27'b0, if_inst[`INST_RS2]};
                    end
                    default: begin
                        dec_op    = alt ? OPENUM_W'(OPENUM_SRAI) : OPENUM_W'(OPENUM_SRLI);
                        dec_imm32 = {27'b0, if_inst[`INST_RS2]};
                    end
                endcase
            end
            OPC_OP: begin
                dec_use_rs2 = 1'b1;
                dec_imm32   = '0;
                case (funct3)
                    FUNCT3_ADD:  dec_op = alt ? OPENUM_W'(OPENUM_SUB) : OPENUM_W'(OPENUM_ADD);
                    FUNCT3_SLL:  dec_op = OPENUM_W'(OPENUM_SLL);
                    FUNCT3_SLT:  dec_op = OPENUM_W'(OPENUM_SLT);
                    FUNCT3_SLTU: dec_op = OPENUM_W'(OPENUM_SLTU);
                    FUNCT3_XOR:  dec_op = OPENUM_W'(OPENUM_XOR);
                    FUNCT3_SR:   dec_op = alt ? OPENUM_W'(OPENUM_SRA) : OPENUM_W'(OPENUM_SRL);
                    FUNCT3_OR:   dec_op = OPENUM_W'(OPENUM_OR);
                    default:     dec_op = OPENUM_W'(OPENUM_AND);
                endcase
            end
            default: dec_known = 1'b0;
        endcase
        // undecodable words become a dependency-free NOP routed to the RS
        if (!dec_known) begin
            dec_op      = OPENUM_W'(OPENUM_NOP);
            dec_rd      = '0;
            dec_imm32   = '0;
            dec_to_lsb  = 1'b0;
            dec_use_rs1 = 1'b0;
            dec_use_rs2 = 1'b0;
        end
    end

    operand_resolve #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .NUM_CDB(NUM_CDB)) u_cap_rs1 (
        .dep_i(reg_rs1_dep), .reg_val_i(reg_rs1_val), .rob_ready_i(rob_rs1_ready), .rob_val_i(rob_rs1_val),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_val_i(cdb_val),
        .val_o(cap_rs1_val), .dep_o(cap_rs1_dep)
    );
    operand_resolve #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .NUM_CDB(NUM_CDB)) u_cap_rs2 (
        .dep_i(reg_rs2_dep), .reg_val_i(reg_rs2_val), .rob_ready_i(rob_rs2_ready), .rob_val_i(rob_rs2_val),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_val_i(cdb_val),
        .val_o(cap_rs2_val), .dep_o(cap_rs2_dep)
    );
    // held operands are re-resolved against the live CDBs only
    operand_resolve #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .NUM_CDB(NUM_CDB)) u_byp_rs1 (
        .dep_i(rs1_dep_q), .reg_val_i(rs1_val_q), .rob_ready_i(1'b0), .rob_val_i('0),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_val_i(cdb_val),
        .val_o(byp_rs1_val), .dep_o(byp_rs1_dep)
    );
    operand_resolve #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .NUM_CDB(NUM_CDB)) u_byp_rs2 (
        .dep_i(rs2_dep_q), .reg_val_i(rs2_val_q), .rob_ready_i(1'b0), .rob_val_i('0),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_val_i(cdb_val),
        .val_o(byp_rs2_val), .dep_o(byp_rs2_dep)
    );

    assign issue_fire = hold_valid_q & rdy_in & ~flush_in & ~rst_in & ~rob_full
                      & (to_lsb_q ? ~lsb_full : ~rs_full);
    assign if_ready   = rdy_in & ~flush_in & ~rst_in & (~hold_valid_q | issue_fire);
    assign capture    = if_valid & if_ready;

    always_comb begin
        hold_valid_d = hold_valid_q;
        to_lsb_d     = to_lsb_q;
        op_d         = op_q;
        rs1_val_d    = rs1_val_q;
        rs1_dep_d    = rs1_dep_q;
        rs2_val_d    = rs2_val_q;
        rs2_dep_d    = rs2_dep_q;
        rd_d         = rd_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        pred_d       = pred_q;
        if (rdy_in) begin
            if (flush_in) begin
                hold_valid_d = 1'b0;
            end else if (capture) begin
                hold_valid_d = 1'b1;
                to_lsb_d     = dec_to_lsb;
                op_d         = dec_op;
                rs1_val_d    = dec_use_rs1 ? cap_rs1_val : '0;
                rs1_dep_d    = dec_use_rs1 ? cap_rs1_dep : '0;
                rs2_val_d    = dec_use_rs2 ? cap_rs2_val : '0;
                rs2_dep_d    = dec_use_rs2 ? cap_rs2_dep : '0;
                rd_d         = dec_rd;
                imm_d        = XLEN'($signed(dec_imm32));
                pc_d         = if_pc;
                pred_d       = if_pred_br;
            end else if (issue_fire) begin
                hold_valid_d = 1'b0;
            end else if (hold_valid_q) begin
                rs1_val_d = byp_rs1_val;
                rs1_dep_d = byp_rs1_dep;
                rs2_val_d = byp_rs2_val;
                rs2_dep_d = byp_rs2_dep;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hold_valid_q <= 1'b0;
            to_lsb_q     <= 1'b0;
            op_q         <= '0;
            rs1_val_q    <= '0;
            rs1_dep_q    <= '0;
            rs2_val_q    <= '0;
            rs2_dep_q    <= '0;
            rd_q         <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            pred_q       <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            to_lsb_q     <= to_lsb_d;
            op_q         <= op_d;
            rs1_val_q    <= rs1_val_d;
            rs1_dep_q    <= rs1_dep_d;
            rs2_val_q    <= rs2_val_d;
            rs2_dep_q    <= rs2_dep_d;
            rd_q         <= rd_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            pred_q       <= pred_d;
        end
    end

    assign reg_rs1_pos   = if_inst[`INST_RS1];
    assign reg_rs2_pos   = if_inst[`INST_RS2];
    assign rob_rs1_check = reg_rs1_dep;
    assign rob_rs2_check = reg_rs2_dep;
    assign issue_to_rs   = hold_valid_q & ~to_lsb_q;
    assign issue_to_lsb  = hold_valid_q & to_lsb_q;
    assign issue_op      = op_q;
    assign issue_rs1_val = byp_rs1_val;
    assign issue_rs1_dep = byp_rs1_dep;
    assign issue_rs2_val = byp_rs2_val;
    assign issue_rs2_dep = byp_rs2_dep;
    assign issue_rd      = rd_q;
    assign issue_imm     = imm_q;
    assign issue_pc      = pc_q;
    assign issue_pred_br = pred_q;
    assign issue_rob_tag = rob_alloc_tag;
endmodule

// File: tb/tb_issue_stage.sv
// tb/tb_issue_stage.sv - scoreboard bench for issue_stage
module tb_issue_stage;
    import issue_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, flush, if_valid, if_ready, if_pred_br;
    logic [31:0] if_pc, if_inst;
    logic [4:0]  reg_rs1_pos, reg_rs2_pos;
    logic [31:0] reg_rs1_val, reg_rs2_val, rob_rs1_val, rob_rs2_val;
    logic [3:0]  reg_rs1_dep, reg_rs2_dep, rob_rs1_check, rob_rs2_check, rob_alloc_tag;
    logic        rob_rs1_ready, rob_rs2_ready;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_val;
    logic        rob_full, rs_full, lsb_full;
    logic        issue_fire, issue_to_rs, issue_to_lsb, issue_pred_br;
    logic [5:0]  issue_op;
    logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
    logic [3:0]  issue_rs1_dep, issue_rs2_dep, issue_rob_tag;
    logic [4:0]  issue_rd;

    issue_stage dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst), .if_pred_br(if_pred_br),
        .reg_rs1_pos(reg_rs1_pos), .reg_rs2_pos(reg_rs2_pos),
        .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val),
        .reg_rs1_dep(reg_rs1_dep), .reg_rs2_dep(reg_rs2_dep),
        .rob_rs1_check(rob_rs1_check), .rob_rs2_check(rob_rs2_check),
        .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
        .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val), .rob_alloc_tag(rob_alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .issue_fire(issue_fire), .issue_to_rs(issue_to_rs), .issue_to_lsb(issue_to_lsb),
        .issue_op(issue_op), .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
        .issue_rs1_dep(issue_rs1_dep), .issue_rs2_dep(issue_rs2_dep), .issue_rd(issue_rd),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_pred_br(issue_pred_br),
        .issue_rob_tag(issue_rob_tag)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] imm, v1, v2, pc;
        logic [3:0]  d1, d2;
        logic [4:0]  rd;
        logic        lsb, pred;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] v1, input logic [3:0] d1,
                        input logic [31:0] v2, input logic [3:0] d2, input logic [4:0] rd, input logic lsb,
                        input logic [31:0] pc, input logic pred);
        exp_t e;
        e.op = op; e.imm = imm; e.v1 = v1; e.d1 = d1; e.v2 = v2; e.d2 = d2;
        e.rd = rd; e.lsb = lsb; e.pc = pc; e.pred = pred;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    always @(negedge clk) begin
        if (issue_fire === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_fire", 32'(issue_fire), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("op",      32'(issue_op),      32'(e.op));
                check("imm",     issue_imm,          e.imm);
                check("rs1_val", issue_rs1_val,      e.v1);
                check("rs1_dep", 32'(issue_rs1_dep), 32'(e.d1));
                check("rs2_val", issue_rs2_val,      e.v2);
                check("rs2_dep", 32'(issue_rs2_dep), 32'(e.d2));
                check("rd",      32'(issue_rd),      32'(e.rd));
                check("to_lsb",  32'(issue_to_lsb),  32'(e.lsb));
                check("to_rs",   32'(issue_to_rs),   32'(!e.lsb));
                check("pc",      issue_pc,           e.pc);
                check("pred",    32'(issue_pred_br), 32'(e.pred));
                check("rob_tag", 32'(issue_rob_tag), 32'd9);
            end
        end
    end

    task automatic idle();
        rdy = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; if_pred_br = 1'b0;
        reg_rs1_val = '0; reg_rs2_val = 32'h0BAD0BAD; reg_rs1_dep = '0; reg_rs2_dep = '0;
        rob_rs1_ready = 1'b0; rob_rs2_ready = 1'b0; rob_rs1_val = 32'hEEEE; rob_rs2_val = 32'hEEEE;
        rob_alloc_tag = 4'd9; cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_fire", 32'(issue_fire), 32'd0);
        check("rst_to_rs", 32'(issue_to_rs), 32'd0);
        step(); rst = 1'b0;
        @(negedge clk);
        check("empty_if_ready", 32'(if_ready), 32'd1);
        check("empty_fire", 32'(issue_fire), 32'd0);

        // ADDI x1,x0,5
        step(); if_valid = 1'b1; if_inst = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011); if_pc = 32'h1000;
        @(negedge clk);
        check("addi_if_ready", 32'(if_ready), 32'd1);
        push(OPENUM_ADDI, 32'd5, 32'd0, 4'd0, 32'd0, 4'd0, 5'd1, 1'b0, 32'h1000, 1'b0);
        step(); if_valid = 1'b0;
        @(negedge clk);
        check("addi_fire", 32'(issue_fire), 32'd1);

        // ADD x3,x1,x2 waiting on tag 3 while RS is full
        step(); if_valid = 1'b1; if_inst = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3); if_pc = 32'h1004;
        reg_rs1_dep = 4'd3; reg_rs2_val = 32'h22; rs_full = 1'b1;
        @(negedge clk);
        push(OPENUM_ADD, 32'd0, 32'h1234, 4'd0, 32'h22, 4'd0, 5'd3, 1'b0, 32'h1004, 1'b0);
        step(); if_valid = 1'b0; reg_rs1_dep = '0;
        @(negedge clk);
        check("add_stall1_fire", 32'(issue_fire), 32'd0);
        check("add_stall1_if_ready", 32'(if_ready), 32'd0);
        check("add_wait_dep", 32'(issue_rs1_dep), 32'd3);
        step(); cdb_valid = 2'b10; cdb_tag = {4'd3, 4'd0}; cdb_val = {32'h1234, 32'h0};
        @(negedge clk);
        check("add_stall2_fire", 32'(issue_fire), 32'd0);
        step(); cdb_valid = '0;
        @(negedge clk);
        check("add_stall3_fire", 32'(issue_fire), 32'd0);
        check("add_snoop_val", issue_rs1_val, 32'h1234);
        check("add_snoop_dep", 32'(issue_rs1_dep), 32'd0);
        step(); rs_full = 1'b0;
        @(negedge clk);
        check("add_fire", 32'(issue_fire), 32'd1);

        // LW x4,8(x5) with tag 5 arriving on CDB ch0 in the fire cycle
        step(); if_valid = 1'b1; if_inst = enc_i(12'd8, 5'd5, 3'b010, 5'd4, 7'b0000011); if_pc = 32'h1008;
        if_pred_br = 1'b1; reg_rs1_dep = 4'd5; reg_rs2_dep = 4'd7; reg_rs2_val = 32'h77;
        @(negedge clk);
        push(OPENUM_LW, 32'd8, 32'h100, 4'd0, 32'd0, 4'd0, 5'd4, 1'b1, 32'h1008, 1'b1);
        step(); if_valid = 1'b0; if_pred_br = 1'b0; reg_rs1_dep = '0; reg_rs2_dep = '0;
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_val = {32'h0, 32'h100};
        @(negedge clk);
        check("lw_fire", 32'(issue_fire), 32'd1);

        // SW x6,-4(x7) immediately followed by SUB x5,x1,x2
        step(); cdb_valid = '0; if_valid = 1'b1; if_inst = enc_s(12'hFFC, 5'd6, 5'd7, 3'b010); if_pc = 32'h100C;
        reg_rs1_val = 32'hAAAA; reg_rs2_val = 32'h5555;
        @(negedge clk);
        check("sw_if_ready", 32'(if_ready), 32'd1);
        push(OPENUM_SW, 32'hFFFFFFFC, 32'hAAAA, 4'd0, 32'h5555, 4'd0, 5'd0, 1'b1, 32'h100C, 1'b0);
        step(); if_inst = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd5); if_pc = 32'h1010;
        reg_rs1_val = 32'h10; reg_rs2_val = 32'h3;
        @(negedge clk);
        check("b2b_if_ready", 32'(if_ready), 32'd1);
        check("b2b_fire", 32'(issue_fire), 32'd1);
        push(OPENUM_SUB, 32'd0, 32'h10, 4'd0, 32'h3, 4'd0, 5'd5, 1'b0, 32'h1010, 1'b0);
        step(); if_valid = 1'b0;
        @(negedge clk);
        check("sub_fire", 32'(issue_fire), 32'd1);

        // BEQ held behind a full RS, then flushed
        step(); if_valid = 1'b1; if_inst = enc_b(13'd16, 5'd2, 5'd1, 3'b000); if_pc = 32'h1014; rs_full = 1'b1;
        reg_rs1_val = '0; reg_rs2_val = '0;
        step(); flush = 1'b1; if_inst = enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011); rs_full = 1'b0;
        @(negedge clk);
        check("flush_fire", 32'(issue_fire), 32'd0);
        check("flush_if_ready", 32'(if_ready), 32'd0);
        step(); flush = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        check("post_flush_fire", 32'(issue_fire), 32'd0);
        check("post_flush_to_rs", 32'(issue_to_rs), 32'd0);
        check("post_flush_if_ready", 32'(if_ready), 32'd1);

        // both CDB channels hit tag 2 at capture, then one frozen cycle
        step(); if_valid = 1'b1; if_inst = enc_i(12'd1, 5'd9, 3'b000, 5'd8, 7'b0010011); if_pc = 32'h1018;
        reg_rs1_dep = 4'd2; cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd2}; cdb_val = {32'd9, 32'd7};
        @(negedge clk);
        push(OPENUM_ADDI, 32'd1, 32'd7, 4'd0, 32'd0, 4'd0, 5'd8, 1'b0, 32'h1018, 1'b0);
        step(); if_valid = 1'b0; cdb_valid = '0; reg_rs1_dep = '0; rdy = 1'b0;
        @(negedge clk);
        check("rdy_low_fire", 32'(issue_fire), 32'd0);
        check("rdy_low_if_ready", 32'(if_ready), 32'd0);
        step(); rdy = 1'b1;
        @(negedge clk);
        check("cdb_prio_fire", 32'(issue_fire), 32'd1);

        // LUI, SRAI via ROB-ready path, then an unknown opcode, back to back
        step(); if_valid = 1'b1; if_inst = {20'h12345, 5'd10, 7'b0110111}; if_pc = 32'h101C;
        reg_rs1_dep = 4'd6; reg_rs2_dep = 4'd6; reg_rs1_val = 32'h11;
        @(negedge clk);
        push(OPENUM_LUI, 32'h12345000, 32'd0, 4'd0, 32'd0, 4'd0, 5'd10, 1'b0, 32'h101C, 1'b0);
        step(); if_inst = enc_i({7'b0100000, 5'd3}, 5'd12, 3'b101, 5'd11, 7'b0010011); if_pc = 32'h1020;
        reg_rs1_dep = 4'd4; rob_rs1_ready = 1'b1; rob_rs1_val = 32'hDEAD;
        @(negedge clk);
        push(OPENUM_SRAI, 32'd3, 32'hDEAD, 4'd0, 32'd0, 4'd0, 5'd11, 1'b0, 32'h1020, 1'b0);
        step(); if_inst = 32'hFFFFFFFF; if_pc = 32'h1024; reg_rs1_dep = 4'd6; rob_rs1_ready = 1'b0;
        @(negedge clk);
        push(OPENUM_NOP, 32'd0, 32'd0, 4'd0, 32'd0, 4'd0, 5'd0, 1'b0, 32'h1024, 1'b0);
        step(); if_valid = 1'b0; reg_rs1_dep = '0; reg_rs2_dep = '0;
        @(negedge clk);
        check("nop_fire", 32'(issue_fire), 32'd1);

        // reset while holding discards the instruction
        step(); if_valid = 1'b1; if_inst = enc_i(12'd2, 5'd0, 3'b000, 5'd2, 7'b0010011); rs_full = 1'b1;
        step(); if_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst_hold_fire", 32'(issue_fire), 32'd0);
        check("rst_hold_if_ready", 32'(if_ready), 32'd0);
        step(); rst = 1'b0; rs_full = 1'b0;
        @(negedge clk);
        check("post_rst_fire", 32'(issue_fire), 32'd0);
        check("post_rst_to_rs", 32'(issue_to_rs), 32'd0);
        step();
        @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Registered decode/issue stage between instruction fetch and the RS/LSB/ROB back end of the Tomasulo core.
- Decodes one RV32I instruction per cycle into a one-entry holding register and resolves operands from the register file, the ROB and NUM_CDB common-data-bus channels.
- While stalled on full back-end structures, keeps snooping the CDBs so held operands wake up.
- Issues with an explicit fire handshake and supports a mispredict flush.

Parameters:
XLEN, 32, data/address width
ROB_IDX_W, 4, ROB tag width; tag 0 reserved = "no dependency"
NUM_CDB, 2, number of result broadcast channels (ALU, LSB, ...)
OPENUM_W, 6, width of the internal op enumeration (shared package)

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low freezes all state
flush_in  in  1  mispredict flush
if_valid  in  1  fetch presents an instruction
if_ready  out  1  stage can accept this cycle
if_pc  in  XLEN  instruction PC
if_inst  in  32  instruction word
if_pred_br  in  1  predicted-taken flag
reg_rs1_pos, reg_rs2_pos  out  5 each  = if_inst[19:15], if_inst[24:20]
reg_rs1_val, reg_rs2_val  in  XLEN each  architectural values
reg_rs1_dep, reg_rs2_dep  in  ROB_IDX_W each  rename tags, 0 = none
rob_rs1_check, rob_rs2_check  out  ROB_IDX_W each  = reg_rsX_dep
rob_rs1_ready, rob_rs2_ready  in  1 each  ROB entry already has its result
rob_rs1_val, rob_rs2_val  in  XLEN each  ROB result values
rob_alloc_tag  in  ROB_IDX_W  tag the ROB assigns on fire
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*ROB_IDX_W  packed tags, channel 0 in LSBs
cdb_val  in  NUM_CDB*XLEN  packed values
rob_full, rs_full, lsb_full  in  1 each  back-end full flags
issue_fire  out  1  instruction issued this cycle
issue_to_rs, issue_to_lsb  out  1 each  destination select, exactly one high when holding
issue_op  out  OPENUM_W  decoded operation
issue_rs1_val, issue_rs2_val  out  XLEN each  operand values
issue_rs1_dep, issue_rs2_dep  out  ROB_IDX_W each  pending tags, 0 = ready
issue_rd  out  5  destination register
issue_imm  out  XLEN  sign-extended immediate
issue_pc  out  XLEN  PC
issue_pred_br  out  1  prediction flag
issue_rob_tag  out  ROB_IDX_W  = rob_alloc_tag

Behaviour:
- State: EMPTY, HOLD (hold_valid bit).
- Reset: hold_valid=0. All registered fields are 0. issue_fire=0 and if_ready=0 during reset.
- issue_fire = hold_valid & rdy_in & !flush_in & !rob_full & (issue_to_rs ? !rs_full : !lsb_full).
- if_ready = rdy_in & !flush_in & (!hold_valid | issue_fire). This gives back-to-back throughput of 1 instruction per cycle.
- Capture condition: if_valid & if_ready. The stage loads the decoded fields and goes to HOLD.
- Fire without capture: the stage goes to EMPTY.
- Capture-time operand resolve, per rsX, in priority order:
  - dep==0: take the reg value.
  - rob_rsX_ready: take the ROB value.
  - Any CDB channel valid with a matching tag: take that value; the lowest channel index wins.
  - Otherwise: value 0, store the tag.
- Unused operands are forced to val=0, dep=0:
  - LUI/AUIPC/JAL: both operands.
  - JALR/OP-IMM/LOAD: rs2.
- Snoop: each rdy_in cycle in HOLD, a held dep matching a valid CDB tag loads the value and clears dep.
- Issue outputs are combinational over the held fields with same-cycle CDB bypass, so a broadcast in the fire cycle is never lost.
- Decode:
  - LUI/AUIPC: imm = {inst[31:12],12'b0}.
  - JAL: J-imm. JALR/OP-IMM/LOAD: I-imm. BRANCH: B-imm. STORE: S-imm. All sign-extended to XLEN.
  - SLLI/SRLI/SRAI: imm = shamt zero-extended. inst[30] selects SRA/SRAI and SUB.
  - BRANCH and STORE: rd forced to 0.
  - LOAD/STORE: issue_to_lsb. All others: issue_to_rs.
  - Unknown opcode or funct3: OPENUM_NOP, to RS, rd=0, no dependencies.
- Flush: no fire and no capture that cycle; hold_valid=0 next cycle. Flush has priority over all other events.
- rdy_in low: no capture, no fire, no snoop; state is held.
- Reset mid-HOLD: the held instruction is discarded; no fire occurs.

Decomposition:
- Shared package holds the OPENUM_* enumeration, opcode, FUNCT3 and FUNCT7 constants, bit-range macros, and the NO_DEP=0 tag.
- Sub-module operand_resolve: pure combinational priority resolve of reg/ROB/CDB for one operand. It is instantiated twice for capture and twice for the fire bypass.

Test Plan:
- ADDI x1,x0,5, stage empty, no full flags -> if_ready=1; next cycle issue_fire=1, op=ADDI, imm=5, rs1 val=0 dep=0, to_rs=1.
- ADD x3,x1,x2 with rs1 dep=3 not ready; rs_full=1 for 3 cycles; CDB ch1 tag3 val=0x1234 in cycle 2 -> no fire; held rs1 val=0x1234 dep=0; fires when rs_full drops.
- LW with rs1 dep=5; CDB ch0 tag5 val=0x100 in the same cycle as the fire condition -> issue_fire=1 with rs1 val=0x100, dep=0, to_lsb=1.
- SW imm=-4 (0xFE...) -> issue_imm=0xFFFFFFFC, issue_rd=0, to_lsb=1.
- BEQ held, flush_in=1 with if_valid=1 -> issue_fire=0, if_ready=0; next cycle EMPTY.
- Two CDB channels both match tag 2 with vals 7 and 9 at capture -> rs1 val=7 (channel 0 wins).
